mux4_scan_ctrl: RTL and testbench
=================================

# mux4_scan_ctrl

Sequencing controller that sits directly upstream of the 4:1 switch-level multiplexer and drives its select lines S1:S0. It also consumes the multiplexer output Y. On a START request it steps through the enabled channels in ascending order. For each channel it holds the select stable for a programmable settle time, then samples Y into the matching bit of a 4-bit result vector. It signals completion with a one-cycle DONE pulse.

## Interface
- SETTLE, default 2, extra cycles the select is held before Y is sampled; legal range 0..15; each channel's select is stable for SETTLE+1 cycles.
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  scan request; sampled only in IDLE.
- MASK  input  4  channel enable; bit n enables channel n (I0..I3); latched when START is accepted.
- Y  input  1  multiplexer output; sampled with a single flop.
- S0  output  1  select LSB to the multiplexer.
- S1  output  1  select MSB to the multiplexer.
- SAMPLE  output  4  captured Y per channel; bit n holds channel n.
- BUSY  output  1  high from the START-accept edge until the edge that enters DONE.
- DONE  output  1  one-cycle completion pulse.

## Operation
- States: IDLE, WAIT, FIN.
- IDLE behaviour:
  - S1:S0 = 00, BUSY = 0, DONE = 0.
  - START=1 with MASK≠0: latch MASK; clear SAMPLE to 0000; CH = lowest set bit of MASK; drive S1:S0 = CH; load counter with SETTLE; set BUSY = 1; go to WAIT.
  - START=1 with MASK=0: clear SAMPLE to 0000; go to FIN (no scan).
- WAIT behaviour:
  - Counter ≠ 0: decrement the counter.
  - Counter = 0: SAMPLE[CH] <= Y.
  - Then, if a higher enabled channel exists: CH = next set bit above CH; S1:S0 = CH on the same edge; reload the counter with SETTLE; stay in WAIT.
  - Otherwise: S1:S0 = 00, BUSY = 0, go to FIN.
- FIN behaviour: DONE = 1 for exactly this cycle; go to IDLE. START in FIN is ignored.
- Masked-off channels are never selected; their SAMPLE bits read 0.
- START while BUSY or in FIN is ignored (not queued). MASK changes during a scan have no effect.
- SAMPLE bits update in place during a scan. SAMPLE holds its final value after DONE until the next accepted START or RST.
- Counter is 4 bits. SETTLE=0 gives one cycle per channel.

## Timing
- Reset values (RST=1 at an edge): state IDLE, S1:S0 = 00, SAMPLE = 0000, BUSY = 0, DONE = 0, counter = 0, latched mask = 0000.
- RST mid-scan aborts the scan with no DONE pulse. RST has priority over START on the same edge.
- Edge E0 is the edge that accepts START.
- With k enabled channels:
  - Channel i (0-based in scan order) is selected from edge E0 + i·(SETTLE+1).
  - It is sampled at edge E0 + (i+1)·(SETTLE+1).
  - DONE is high during the cycle after edge E0 + k·(SETTLE+1).
  - The earliest next START is accepted one cycle after DONE.
- Select transitions between enabled channels are edge-to-edge with no idle gap.
- MASK=0 case: DONE is high during the cycle after E0.
- Y must be stable before the sampling edge. Y has no synchronizer, so mux inputs are assumed to be driven from the CLK domain.

## Test plan
- Reset: hold RST for 2 cycles with START=1 -> S1:S0=00, SAMPLE=0000, BUSY=0, DONE=0 throughout.
- Full scan: SETTLE=2, MASK=1111, model the mux with I3..I0=1010 -> S1:S0 = 00,01,10,11, each held 3 cycles; SAMPLE=1010; DONE rises at edge E0+12; BUSY high for 12 cycles.
- Sparse mask: SETTLE=0, MASK=0101, I3..I0=1111 -> only channels 0 and 2 selected, 1 cycle each; SAMPLE=0101; DONE at edge E0+2.
- Empty mask: START with MASK=0000 after a prior SAMPLE=1111 -> SAMPLE=0000, select stays 00, DONE high in the cycle after E0, BUSY never asserted.
- START re-pulsed at cycle E0+4 of a MASK=1111, SETTLE=2 scan -> ignored; exactly one DONE pulse; result as in the full scan.
- RST asserted at cycle E0+5 mid-scan -> next edge gives all reset values; no DONE pulse; a subsequent START performs a complete, correct scan.

Source files
------------

// File: rtl/mux4_scan_ctrl.sv
// ============================================================================
// Module   : mux4_scan_ctrl
// Brief    : Steps the select lines of a 4:1 mux through enabled channels,
//            holds each for SETTLE+1 cycles and captures Y per channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux4_scan_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [3:0] MASK,
  input  logic       Y,
  output logic       S0,
  output logic       S1,
  output logic [3:0] SAMPLE,
  output logic       BUSY,
  output logic       DONE
);

  localparam logic [3:0] C_SETTLE = 4'(SETTLE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t     r_state;
  logic [3:0] r_mask;
  logic [1:0] r_ch;
  logic [1:0] r_sel;
  logic [3:0] r_cnt;
  logic [3:0] r_sample;
  logic       r_busy;
  logic       r_done;

  logic [1:0] w_first;
  logic [1:0] w_next;
  logic       w_has_next;

  // Descending loops so the lowest qualifying bit is the one left standing.
  always_comb begin
    w_first = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (MASK[i]) w_first = 2'(i);
    end
  end

  always_comb begin
    w_next     = 2'd0;
    w_has_next = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (r_mask[i] && (i > int'(r_ch))) begin
        w_next     = 2'(i);
        w_has_next = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_mask   <= 4'b0000;
      r_ch     <= 2'd0;
      r_sel    <= 2'd0;
      r_cnt    <= 4'd0;
      r_sample <= 4'b0000;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_sample <= 4'b0000;
            if (MASK != 4'b0000) begin
              r_mask  <= MASK;
              r_ch    <= w_first;
              r_sel   <= w_first;
              r_cnt   <= C_SETTLE;
              r_busy  <= 1'b1;
              r_state <= ST_WAIT;
            end else begin
              r_done  <= 1'b1;
              r_state <= ST_FIN;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_sample[r_ch] <= Y;
            if (w_has_next) begin
              r_ch  <= w_next;
              r_sel <= w_next;
              r_cnt <= C_SETTLE;
            end else begin
              r_sel   <= 2'd0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_FIN;
            end
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign S0     = r_sel[0];
  assign S1     = r_sel[1];
  assign SAMPLE = r_sample;
  assign BUSY   = r_busy;
  assign DONE   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_mux4_scan_ctrl.sv
// ============================================================================
// Module   : tb_mux4_scan_ctrl
// Brief    : Scoreboard bench for mux4_scan_ctrl with SETTLE=2 and SETTLE=0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux4_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] mask = 4'b0000;
  logic [3:0] data = 4'b0000;
  logic       obs = 1'b0;

  logic       s0_2, s1_2, busy_2, done_2, y_2;
  logic [3:0] sample_2;
  logic       s0_0, s1_0, busy_0, done_0, y_0;
  logic [3:0] sample_0;

  assign y_2 = data[{s1_2, s0_2}];
  assign y_0 = data[{s1_0, s0_0}];

  mux4_scan_ctrl #(.SETTLE(2)) dut2 (
    .CLK(clk), .RST(rst), .START(start), .MASK(mask), .Y(y_2),
    .S0(s0_2), .S1(s1_2), .SAMPLE(sample_2), .BUSY(busy_2), .DONE(done_2)
  );

  mux4_scan_ctrl #(.SETTLE(0)) dut0 (
    .CLK(clk), .RST(rst), .START(start), .MASK(mask), .Y(y_0),
    .S0(s0_0), .S1(s1_0), .SAMPLE(sample_0), .BUSY(busy_0), .DONE(done_0)
  );

  logic [1:0] o_sel;
  logic [3:0] o_sample;
  logic       o_busy, o_done;
  assign o_sel    = obs ? {s1_0, s0_0} : {s1_2, s0_2};
  assign o_sample = obs ? sample_0 : sample_2;
  assign o_busy   = obs ? busy_0 : busy_2;
  assign o_done   = obs ? done_0 : done_2;

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         t0 = 0;
  logic       rst_seen = 1'b0;
  logic [1:0] sq[$];
  logic [3:0] rq[$];
  int         lq[$];

  always @(posedge clk) begin
    cyc++;
    rst_seen <= rst;
  end

  // Monitor: per-cycle select trace while busy, result and latency on DONE.
  always @(negedge clk) begin
    logic [1:0] esel;
    logic [3:0] eres;
    int         elat;
    if (rst_seen) begin
      checks++;
      if (o_sel != 2'd0 || o_sample != 4'd0 || o_busy || o_done) begin
        errors++;
        $display("FAIL reset: sel=%b sample=%b busy=%b done=%b, required 00 0000 0 0",
                 o_sel, o_sample, o_busy, o_done);
      end
    end else begin
      if (o_busy) begin
        checks++;
        if (sq.size() == 0) begin
          errors++;
          $display("FAIL busy_extra: busy=1 at cycle %0d, required busy=0", cyc);
        end else begin
          esel = sq.pop_front();
          if (o_sel != esel) begin
            errors++;
            $display("FAIL select: sel=%b, required %b (cycle %0d)", o_sel, esel, cyc);
          end
        end
      end else begin
        checks++;
        if (o_sel != 2'd0) begin
          errors++;
          $display("FAIL idle_sel: sel=%b, required 00 (cycle %0d)", o_sel, cyc);
        end
      end
      if (o_done) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL done_extra: done=1 at cycle %0d, required no pulse", cyc);
        end else begin
          eres = rq.pop_front();
          elat = lq.pop_front();
          if (o_sample != eres) begin
            errors++;
            $display("FAIL sample: sample=%b, required %b", o_sample, eres);
          end
          checks++;
          if (cyc - t0 != elat) begin
            errors++;
            $display("FAIL done_latency: done after E0+%0d, required E0+%0d", cyc - t0, elat);
          end
          checks++;
          if (sq.size() != 0 || o_busy) begin
            errors++;
            $display("FAIL busy_at_done: busy=%b pending_selects=%0d, required 0 0",
                     o_busy, sq.size());
          end
        end
      end
    end
  end

  task automatic push_scan(input logic [3:0] m, input logic [3:0] d, input int settle,
                           input logic [3:0] exp_sample, input int exp_lat);
    mask = m;
    data = d;
    for (int ch = 0; ch < 4; ch++) begin
      if (m[ch]) begin
        for (int k = 0; k <= settle; k++) sq.push_back(2'(ch));
      end
    end
    rq.push_back(exp_sample);
    lq.push_back(exp_lat);
  endtask

  task automatic go();
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && rq.size() != 0; i++) @(posedge clk);
    if (rq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: no DONE within 100 cycles, required DONE");
      sq.delete();
      rq.delete();
      lq.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held two cycles with START asserted: reset must win.
    rst   = 1'b1;
    start = 1'b1;
    mask  = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;

    // Full scan, SETTLE=2.
    push_scan(4'b1111, 4'b1010, 2, 4'b1010, 12);
    go();
    wait_done();

    // START re-pulsed at E0+4 with a changed MASK: must be ignored.
    push_scan(4'b1111, 4'b1010, 2, 4'b1010, 12);
    go();
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    mask  = 4'b0001;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();

    // Reset mid-scan: no DONE, all outputs back to reset values.
    push_scan(4'b1111, 4'b0101, 2, 4'b0101, 12);
    go();
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sq.delete();
    rq.delete();
    lq.delete();
    repeat (3) @(posedge clk);
    #1;

    // Complete scan after the abort, leaving SAMPLE=1111.
    push_scan(4'b1111, 4'b1111, 2, 4'b1111, 12);
    go();
    wait_done();

    // Empty mask: SAMPLE cleared, no BUSY, DONE right after E0.
    push_scan(4'b0000, 4'b1111, 2, 4'b0000, 0);
    go();
    wait_done();

    // SETTLE=0 instance.
    obs = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    push_scan(4'b0101, 4'b1111, 0, 4'b0101, 2);
    go();
    wait_done();
    repeat (8) @(posedge clk);
    #1;

    push_scan(4'b1010, 4'b0110, 0, 4'b0010, 2);
    go();
    wait_done();
    repeat (8) @(posedge clk);
    #1;

    push_scan(4'b1111, 4'b1001, 0, 4'b1001, 4);
    go();
    wait_done();
    repeat (8) @(posedge clk);
    #1;

    push_scan(4'b1000, 4'b1000, 0, 4'b1000, 1);
    go();
    wait_done();

    checks++;
    if (sq.size() != 0 || rq.size() != 0) begin
      errors++;
      $display("FAIL leftover: selects=%0d results=%0d, required 0 0", sq.size(), rq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
